// File: rtl/xdma_core_model_pkg.sv
`default_nettype none
// ============================================================================
// Module   : xdma_core_model_pkg
// Brief    : Shared types and helpers for the XDMA core behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
package xdma_core_model_pkg;

  localparam int C_CFG_REGS = 16;

  typedef enum logic [0:0] {
    LINK_TRAINING = 1'b0,
    LINK_ACTIVE   = 1'b1
  } link_state_e;

  function automatic logic [31:0] be_merge(input logic [31:0] old_v,
                                           input logic [31:0] new_v,
                                           input logic [3:0]  be);
    logic [31:0] r;
    r = old_v;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) r[8*b +: 8] = new_v[8*b +: 8];
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/xdma_loopback_fifo.sv
`default_nettype none
// ============================================================================
// Module   : xdma_loopback_fifo
// Brief    : Synchronous FIFO, registered storage, no fall-through (DEPTH >= 2).
// Revision : 1.0 - initial release
// ============================================================================
module xdma_loopback_fifo
  import xdma_core_model_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int C_PTR_W = $clog2(DEPTH);
  localparam int C_CNT_W = C_PTR_W + 1;

  logic [WIDTH-1:0]   mem_q [DEPTH];
  logic [C_PTR_W-1:0] wr_ptr_q;
  logic [C_PTR_W-1:0] rd_ptr_q;
  logic [C_CNT_W-1:0] count_q;
  logic               w_do_push;
  logic               w_do_pop;

  assign full_o    = (count_q == C_CNT_W'(DEPTH));
  assign empty_o   = (count_q == '0);
  assign w_do_push = push_i & ~full_o;
  assign w_do_pop  = pop_i & ~empty_o;
  // Empty reads as zero so the stream outputs stay quiet after a flush.
  assign rdata_o   = empty_o ? '0 : mem_q[rd_ptr_q];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (w_do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (w_do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule
`default_nettype wire

// File: rtl/xdma_core_model.sv
`default_nettype none
// ============================================================================
// Module   : xdma_core_model
// Brief    : Behavioural XDMA stand-in: link-up timer, C2H->H2C loopback,
//            idle AXI-Lite master, user IRQ handshake, cfg_mgmt registers.
// Revision : 1.0 - initial release
// ============================================================================
module xdma_core_model
  import xdma_core_model_pkg::*;
#(
  parameter int C_DATA_WIDTH               = 128,
  parameter int PL_LINK_CAP_MAX_LINK_WIDTH = 4,
  parameter int LINK_UP_DELAY              = 16,
  parameter int FIFO_DEPTH                 = 16
) (
  input  logic                                  sys_clk,
  input  logic                                  sys_rst,
  output logic [PL_LINK_CAP_MAX_LINK_WIDTH-1:0] pci_exp_txp,
  output logic [PL_LINK_CAP_MAX_LINK_WIDTH-1:0] pci_exp_txn,
  input  logic [PL_LINK_CAP_MAX_LINK_WIDTH-1:0] pci_exp_rxp,
  input  logic [PL_LINK_CAP_MAX_LINK_WIDTH-1:0] pci_exp_rxn,
  input  logic [C_DATA_WIDTH-1:0]               s_axis_c2h_tdata_0,
  input  logic [C_DATA_WIDTH/8-1:0]             s_axis_c2h_tkeep_0,
  input  logic                                  s_axis_c2h_tlast_0,
  input  logic                                  s_axis_c2h_tvalid_0,
  output logic                                  s_axis_c2h_tready_0,
  output logic [C_DATA_WIDTH-1:0]               m_axis_h2c_tdata_0,
  output logic [C_DATA_WIDTH/8-1:0]             m_axis_h2c_tkeep_0,
  output logic                                  m_axis_h2c_tlast_0,
  output logic                                  m_axis_h2c_tvalid_0,
  input  logic                                  m_axis_h2c_tready_0,
  output logic [31:0]                           m_axil_awaddr,
  output logic [2:0]                            m_axil_awprot,
  output logic                                  m_axil_awvalid,
  input  logic                                  m_axil_awready,
  output logic [31:0]                           m_axil_wdata,
  output logic [3:0]                            m_axil_wstrb,
  output logic                                  m_axil_wvalid,
  input  logic                                  m_axil_wready,
  input  logic                                  m_axil_bvalid,
  input  logic [1:0]                            m_axil_bresp,
  output logic                                  m_axil_bready,
  output logic [31:0]                           m_axil_araddr,
  output logic [2:0]                            m_axil_arprot,
  output logic                                  m_axil_arvalid,
  input  logic                                  m_axil_arready,
  input  logic                                  m_axil_rvalid,
  input  logic [1:0]                            m_axil_rresp,
  input  logic [31:0]                           m_axil_rdata,
  output logic                                  m_axil_rready,
  input  logic                                  usr_irq_req,
  output logic                                  usr_irq_ack,
  output logic                                  msi_enable,
  output logic [2:0]                            msi_vector_width,
  input  logic [18:0]                           cfg_mgmt_addr,
  input  logic                                  cfg_mgmt_write,
  input  logic [31:0]                           cfg_mgmt_write_data,
  input  logic [3:0]                            cfg_mgmt_byte_enable,
  input  logic                                  cfg_mgmt_read,
  input  logic                                  cfg_mgmt_type1_cfg_reg_access,
  output logic [31:0]                           cfg_mgmt_read_data,
  output logic                                  cfg_mgmt_read_write_done,
  output logic                                  axi_aclk,
  output logic                                  axi_aresetn,
  output logic                                  user_lnk_up
);

  localparam int C_KEEP_W  = C_DATA_WIDTH / 8;
  localparam int C_ENTRY_W = C_DATA_WIDTH + C_KEEP_W + 1;
  localparam int C_LCNT_W  = (LINK_UP_DELAY > 1) ? $clog2(LINK_UP_DELAY) : 1;

  link_state_e         link_state_q, link_state_d;
  logic [C_LCNT_W-1:0] link_cnt_q, link_cnt_d;

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      link_state_q <= LINK_TRAINING;
      link_cnt_q   <= '0;
    end else begin
      link_state_q <= link_state_d;
      link_cnt_q   <= link_cnt_d;
    end
  end

  always_comb begin
    link_state_d = link_state_q;
    link_cnt_d   = link_cnt_q;
    case (link_state_q)
      LINK_TRAINING: begin
        if (link_cnt_q == C_LCNT_W'(LINK_UP_DELAY - 1)) link_state_d = LINK_ACTIVE;
        else                                             link_cnt_d   = link_cnt_q + 1'b1;
      end
      LINK_ACTIVE: link_state_d = LINK_ACTIVE;
      default:     link_state_d = LINK_TRAINING;
    endcase
  end

  assign user_lnk_up      = (link_state_q == LINK_ACTIVE);
  assign axi_aresetn      = user_lnk_up;
  assign axi_aclk         = sys_clk;
  assign msi_enable       = user_lnk_up;
  assign msi_vector_width = 3'd0;

  // Lanes held in electrical idle.
  assign pci_exp_txp = '0;
  assign pci_exp_txn = '1;

  assign m_axil_awaddr  = '0;
  assign m_axil_awprot  = '0;
  assign m_axil_awvalid = 1'b0;
  assign m_axil_wdata   = '0;
  assign m_axil_wstrb   = '0;
  assign m_axil_wvalid  = 1'b0;
  assign m_axil_bready  = 1'b1;
  assign m_axil_araddr  = '0;
  assign m_axil_arprot  = '0;
  assign m_axil_arvalid = 1'b0;
  assign m_axil_rready  = 1'b1;

  logic                 w_full, w_empty, w_push, w_pop;
  logic [C_ENTRY_W-1:0] w_head;

  assign s_axis_c2h_tready_0 = user_lnk_up & ~w_full;
  assign w_push              = s_axis_c2h_tvalid_0 & s_axis_c2h_tready_0;
  assign m_axis_h2c_tvalid_0 = ~w_empty;
  assign w_pop               = m_axis_h2c_tvalid_0 & m_axis_h2c_tready_0;
  assign {m_axis_h2c_tlast_0, m_axis_h2c_tkeep_0, m_axis_h2c_tdata_0} = w_head;

  xdma_loopback_fifo #(
    .WIDTH (C_ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_loopback_fifo (
    .clk_i   (sys_clk),
    .rst_i   (sys_rst),
    .push_i  (w_push),
    .wdata_i ({s_axis_c2h_tlast_0, s_axis_c2h_tkeep_0, s_axis_c2h_tdata_0}),
    .pop_i   (w_pop),
    .rdata_o (w_head),
    .full_o  (w_full),
    .empty_o (w_empty)
  );

  logic irq_req_q, irq_ack_q;

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      irq_req_q <= 1'b0;
      irq_ack_q <= 1'b0;
    end else begin
      irq_req_q <= usr_irq_req;
      irq_ack_q <= user_lnk_up & usr_irq_req & ~irq_req_q;
    end
  end

  assign usr_irq_ack = irq_ack_q;

  logic [31:0] cfg_regs_q [C_CFG_REGS];
  logic [31:0] cfg_rdata_q;
  logic        cfg_done_q;
  logic [3:0]  w_cfg_idx;

  assign w_cfg_idx = cfg_mgmt_addr[3:0];

  // Read sees the pre-write contents when both strobes coincide.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      for (int i = 0; i < C_CFG_REGS; i++) cfg_regs_q[i] <= '0;
      cfg_rdata_q <= '0;
      cfg_done_q  <= 1'b0;
    end else begin
      cfg_done_q <= cfg_mgmt_write | cfg_mgmt_read;
      if (cfg_mgmt_read)  cfg_rdata_q <= cfg_regs_q[w_cfg_idx];
      if (cfg_mgmt_write) cfg_regs_q[w_cfg_idx] <=
          be_merge(cfg_regs_q[w_cfg_idx], cfg_mgmt_write_data, cfg_mgmt_byte_enable);
    end
  end

  assign cfg_mgmt_read_data       = cfg_rdata_q;
  assign cfg_mgmt_read_write_done = cfg_done_q;

  logic w_unused;
  assign w_unused = ^{pci_exp_rxp, pci_exp_rxn, m_axil_awready, m_axil_wready,
                      m_axil_bvalid, m_axil_bresp, m_axil_arready, m_axil_rvalid,
                      m_axil_rresp, m_axil_rdata, cfg_mgmt_type1_cfg_reg_access,
                      cfg_mgmt_addr[18:4]};

endmodule
`default_nettype wire

// File: tb/tb_xdma_core_model.sv
`default_nettype none
// ============================================================================
// Module   : tb_xdma_core_model
// Brief    : Scoreboard bench for xdma_core_model with a queue-based stream model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_xdma_core_model;

  localparam int DW    = 128;
  localparam int KW    = DW / 8;
  localparam int LW    = 4;
  localparam int LUD   = 16;
  localparam int DEPTH = 16;
  localparam int EW    = DW + KW + 1;

  logic           sys_clk = 1'b0;
  logic           sys_rst = 1'b1;
  logic [LW-1:0]  txp, txn, rxp, rxn;
  logic [DW-1:0]  c2h_tdata, h2c_tdata;
  logic [KW-1:0]  c2h_tkeep, h2c_tkeep;
  logic           c2h_tlast, c2h_tvalid, c2h_tready;
  logic           h2c_tlast, h2c_tvalid, h2c_tready;
  logic [31:0]    awaddr, wdata, araddr, rdata, cfg_wdata, cfg_rdata;
  logic [2:0]     awprot, arprot, msi_vw;
  logic [3:0]     wstrb, cfg_be;
  logic           awvalid, awready, wvalid, wready, bvalid, bready;
  logic           arvalid, arready, rvalid, rready;
  logic [1:0]     bresp, rresp;
  logic           irq_req, irq_ack, msi_en;
  logic [18:0]    cfg_addr;
  logic           cfg_wr, cfg_rd, cfg_t1, cfg_done;
  logic           aclk, aresetn, lnk_up;

  int             vectors = 0;
  int             miscompares = 0;
  int             rel_cnt = 0;
  int             rdy_mode = 0;
  logic [EW-1:0]  exp_q[$];
  logic [31:0]    cfg_model [16];
  logic [31:0]    last_rd = '0;
  logic           mon_lnk, mon_rdy;

  always #5 sys_clk = ~sys_clk;

  xdma_core_model #(
    .C_DATA_WIDTH (DW), .PL_LINK_CAP_MAX_LINK_WIDTH (LW),
    .LINK_UP_DELAY (LUD), .FIFO_DEPTH (DEPTH)
  ) dut (
    .sys_clk (sys_clk), .sys_rst (sys_rst),
    .pci_exp_txp (txp), .pci_exp_txn (txn), .pci_exp_rxp (rxp), .pci_exp_rxn (rxn),
    .s_axis_c2h_tdata_0 (c2h_tdata), .s_axis_c2h_tkeep_0 (c2h_tkeep),
    .s_axis_c2h_tlast_0 (c2h_tlast), .s_axis_c2h_tvalid_0 (c2h_tvalid),
    .s_axis_c2h_tready_0 (c2h_tready),
    .m_axis_h2c_tdata_0 (h2c_tdata), .m_axis_h2c_tkeep_0 (h2c_tkeep),
    .m_axis_h2c_tlast_0 (h2c_tlast), .m_axis_h2c_tvalid_0 (h2c_tvalid),
    .m_axis_h2c_tready_0 (h2c_tready),
    .m_axil_awaddr (awaddr), .m_axil_awprot (awprot), .m_axil_awvalid (awvalid),
    .m_axil_awready (awready), .m_axil_wdata (wdata), .m_axil_wstrb (wstrb),
    .m_axil_wvalid (wvalid), .m_axil_wready (wready), .m_axil_bvalid (bvalid),
    .m_axil_bresp (bresp), .m_axil_bready (bready), .m_axil_araddr (araddr),
    .m_axil_arprot (arprot), .m_axil_arvalid (arvalid), .m_axil_arready (arready),
    .m_axil_rvalid (rvalid), .m_axil_rresp (rresp), .m_axil_rdata (rdata),
    .m_axil_rready (rready),
    .usr_irq_req (irq_req), .usr_irq_ack (irq_ack),
    .msi_enable (msi_en), .msi_vector_width (msi_vw),
    .cfg_mgmt_addr (cfg_addr), .cfg_mgmt_write (cfg_wr), .cfg_mgmt_write_data (cfg_wdata),
    .cfg_mgmt_byte_enable (cfg_be), .cfg_mgmt_read (cfg_rd),
    .cfg_mgmt_type1_cfg_reg_access (cfg_t1), .cfg_mgmt_read_data (cfg_rdata),
    .cfg_mgmt_read_write_done (cfg_done),
    .axi_aclk (aclk), .axi_aresetn (aresetn), .user_lnk_up (lnk_up)
  );

  task automatic chk(input string nm, input logic [159:0] act, input logic [159:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Cycles since reset release; the link is expected up once LUD edges have elapsed.
  always @(posedge sys_clk) begin
    if (sys_rst)             rel_cnt <= 0;
    else if (rel_cnt < 1000) rel_cnt <= rel_cnt + 1;
  end

  initial begin
    forever begin
      @(posedge sys_clk);
      #2;
      case (rdy_mode)
        0:       h2c_tready = 1'b0;
        1:       h2c_tready = 1'b1;
        default: h2c_tready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor: the stream model is a plain queue bounded by DEPTH entries.
  always @(negedge sys_clk) begin
    if (sys_rst) exp_q.delete();
    mon_lnk = !sys_rst && (rel_cnt >= LUD);
    mon_rdy = mon_lnk && (exp_q.size() < DEPTH);
    chk("user_lnk_up", lnk_up, mon_lnk);
    chk("axi_aresetn", aresetn, mon_lnk);
    chk("msi_enable", msi_en, mon_lnk);
    chk("c2h_tready", c2h_tready, mon_rdy);
    chk("h2c_tvalid", h2c_tvalid, exp_q.size() != 0);
    chk("static_outs",
        {txp, txn, awaddr, awprot, awvalid, wdata, wstrb, wvalid,
         araddr, arprot, arvalid, bready, rready, msi_vw},
        {4'h0, 4'hF, 32'h0, 3'h0, 1'b0, 32'h0, 4'h0, 1'b0,
         32'h0, 3'h0, 1'b0, 1'b1, 1'b1, 3'h0});
    if (exp_q.size() != 0) begin
      chk("h2c_beat", {h2c_tlast, h2c_tkeep, h2c_tdata}, exp_q[0]);
      if (h2c_tready) void'(exp_q.pop_front());
    end
    if (c2h_tvalid && mon_rdy) exp_q.push_back({c2h_tlast, c2h_tkeep, c2h_tdata});
  end

  task automatic send_beat(input logic [DW-1:0] d, input logic [KW-1:0] k, input logic l);
    logic acc;
    bit   ok;
    ok = 0;
    c2h_tdata = d; c2h_tkeep = k; c2h_tlast = l; c2h_tvalid = 1'b1;
    for (int t = 0; t < 500; t++) begin
      @(negedge sys_clk);
      acc = c2h_tready;
      @(posedge sys_clk);
      #2;
      if (acc) begin ok = 1; break; end
    end
    c2h_tvalid = 1'b0;
    if (!ok) chk("c2h_accept_timeout", 1'b0, 1'b1);
  endtask

  task automatic irq_check(input bit expect_pulse);
    @(posedge sys_clk); #2;
    irq_req = 1'b1;
    for (int i = 0; i < 7; i++) begin
      @(negedge sys_clk);
      chk("usr_irq_ack", irq_ack, expect_pulse && (i == 1));
    end
    @(posedge sys_clk); #2;
    irq_req = 1'b0;
    @(negedge sys_clk);
    chk("usr_irq_ack_idle", irq_ack, 1'b0);
  endtask

  task automatic cfg_access(input bit w, input bit r, input logic [18:0] a,
                            input logic [31:0] d, input logic [3:0] be);
    logic [31:0] mask, exp_rd;
    @(posedge sys_clk); #2;
    cfg_addr = a; cfg_wdata = d; cfg_be = be; cfg_wr = w; cfg_rd = r;
    @(posedge sys_clk);
    exp_rd = cfg_model[a[3:0]];
    mask   = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    if (w) cfg_model[a[3:0]] = (cfg_model[a[3:0]] & ~mask) | (d & mask);
    if (r) last_rd = exp_rd;
    @(negedge sys_clk);
    chk("cfg_done", cfg_done, 1'b1);
    chk("cfg_read_data", cfg_rdata, last_rd);
    cfg_wr = 1'b0; cfg_rd = 1'b0;
    @(negedge sys_clk);
    chk("cfg_done_clear", cfg_done, 1'b0);
    chk("cfg_read_hold", cfg_rdata, last_rd);
  endtask

  initial begin
    int n;
    rxp = 4'($urandom); rxn = 4'($urandom);
    awready = 1'b1; wready = 1'b1; arready = 1'b1;
    bvalid = 1'b0; bresp = 2'b00; rvalid = 1'b0; rresp = 2'b00; rdata = 32'hDEAD_BEEF;
    c2h_tdata = '0; c2h_tkeep = '0; c2h_tlast = 1'b0; c2h_tvalid = 1'b0;
    h2c_tready = 1'b0; irq_req = 1'b0;
    cfg_addr = '0; cfg_wr = 1'b0; cfg_rd = 1'b0; cfg_wdata = '0; cfg_be = '0; cfg_t1 = 1'b0;
    for (int i = 0; i < 16; i++) cfg_model[i] = '0;

    // Reset state
    @(negedge sys_clk);
    chk("rst_irq_ack", irq_ack, 1'b0);
    chk("rst_cfg_rdata", cfg_rdata, 32'h0);
    chk("rst_cfg_done", cfg_done, 1'b0);
    chk("rst_h2c_beat", {h2c_tlast, h2c_tkeep, h2c_tdata}, '0);

    // Link-up timing from release
    @(posedge sys_clk); #2;
    sys_rst = 1'b0;
    n = 0;
    while (n < 100) begin
      @(posedge sys_clk);
      n++;
      @(negedge sys_clk);
      if (lnk_up) break;
    end
    chk("link_delay_cycles", n, LUD);
    @(posedge sys_clk); #2;
    chk("axi_aclk", aclk, sys_clk);

    // Three-beat packet, sink always ready
    rdy_mode = 1;
    @(posedge sys_clk); #2;
    send_beat(128'h1, 16'hFFFF, 1'b0);
    send_beat(128'h2, 16'hFFFF, 1'b0);
    send_beat(128'h3, 16'hFFFF, 1'b1);
    repeat (4) @(posedge sys_clk);
    #2;

    // Fill to capacity with sink stalled, then drain
    rdy_mode = 0;
    @(posedge sys_clk); #2;
    for (int i = 0; i < 16; i++) send_beat(DW'(32'h100 + i), 16'hFFFF, i == 15);
    fork
      send_beat(DW'(32'h200), 16'h00FF, 1'b1);
      begin
        repeat (5) begin
          @(negedge sys_clk);
          chk("full_tready", c2h_tready, 1'b0);
        end
        rdy_mode = 1;
      end
    join
    repeat (20) @(posedge sys_clk);
    #2;

    // Randomized traffic with random backpressure and gaps
    rdy_mode = 2;
    for (int i = 0; i < 150; i++) begin
      repeat ($urandom_range(0, 2)) begin @(posedge sys_clk); #2; end
      send_beat({$urandom(), $urandom(), $urandom(), $urandom()}, KW'($urandom()),
                1'($urandom_range(0, 1)));
    end
    rdy_mode = 1;
    repeat (20) @(posedge sys_clk);
    #2;

    // User interrupt: single pulse per rising edge
    irq_check(1'b1);
    irq_check(1'b1);

    // cfg_mgmt register file
    cfg_access(1'b1, 1'b0, 19'd3, 32'hAABB_CCDD, 4'b0101);
    cfg_access(1'b0, 1'b1, 19'd3, 32'h0, 4'h0);
    chk("cfg_bytes_0x00BB00DD", cfg_rdata, 32'h00BB_00DD);
    cfg_access(1'b1, 1'b1, 19'h7FF13, 32'h1234_5678, 4'b1111);
    for (int i = 0; i < 12; i++) begin
      logic wr_b, rd_b;
      wr_b = 1'($urandom_range(0, 1));
      rd_b = wr_b ? 1'($urandom_range(0, 1)) : 1'b1;
      cfg_access(wr_b, rd_b, 19'($urandom()), $urandom(), 4'($urandom()));
    end

    // Reset with beats pending
    rdy_mode = 0;
    @(posedge sys_clk); #2;
    for (int i = 0; i < 4; i++) send_beat(DW'(32'h300 + i), 16'hFFFF, i == 3);
    sys_rst = 1'b1;
    #1;
    chk("rst_mid_h2c_tvalid", h2c_tvalid, 1'b0);
    chk("rst_mid_lnk_up", lnk_up, 1'b0);
    chk("rst_mid_aresetn", aresetn, 1'b0);
    chk("rst_mid_c2h_tready", c2h_tready, 1'b0);
    repeat (3) @(posedge sys_clk);
    #2;
    sys_rst = 1'b0;
    for (int i = 0; i < 16; i++) cfg_model[i] = '0;
    irq_check(1'b0);
    n = 0;
    while (n < 40 && !lnk_up) begin
      @(negedge sys_clk);
      n++;
    end
    chk("relink", lnk_up, 1'b1);
    @(posedge sys_clk); #2;
    rdy_mode = 1;
    send_beat(128'hA5, 16'h000F, 1'b1);
    repeat (6) @(posedge sys_clk);
    #2;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    miscompares++;
    $display("FAIL watchdog: simulation time limit reached at t=%0t", $time);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
